switch_debouncer: RTL

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

---
 rtl/switch_debouncer.sv | 107 ++++++++++
 1 files changed

// File: rtl/switch_debouncer.sv
// Multi-channel switch debouncer: two-flop synchronizer, per-channel stability counter,
// registered debounced level, one-cycle rise/fall pulses and a busy flag.
module switch_debouncer #(
    parameter int unsigned NUM_SW          = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] switches,
    output logic [NUM_SW-1:0] sw_db,
    output logic [NUM_SW-1:0] sw_rise,
    output logic [NUM_SW-1:0] sw_fall,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } ch_state_t;

    logic [NUM_SW-1:0] r_sync1;
    logic [NUM_SW-1:0] r_sync2;
    logic [NUM_SW-1:0] r_db;
    logic [NUM_SW-1:0] r_rise;
    logic [NUM_SW-1:0] r_fall;
    logic              r_busy;
    logic [CNT_W-1:0]  r_cnt [NUM_SW];

    ch_state_t         w_state [NUM_SW];
    logic [NUM_SW-1:0] w_db_nxt;
    logic [NUM_SW-1:0] w_rise_nxt;
    logic [NUM_SW-1:0] w_fall_nxt;
    logic              w_busy_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt [NUM_SW];

    // Metastability guard; only r_sync2 is observed downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= switches;
            r_sync2 <= r_sync1;
        end
    end

    // Per-channel state register: debounced level, counter, pulses, busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db   <= '0;
            r_rise <= '0;
            r_fall <= '0;
            r_busy <= 1'b0;
            for (int unsigned i = 0; i < NUM_SW; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_db   <= w_db_nxt;
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
            r_busy <= w_busy_nxt;
            for (int unsigned i = 0; i < NUM_SW; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // Channel state is implied by disagreement between synchronized input and accepted level.
    always_comb begin
        w_db_nxt   = r_db;
        w_rise_nxt = '0;
        w_fall_nxt = '0;
        w_busy_nxt = 1'b0;
        for (int unsigned i = 0; i < NUM_SW; i++) begin
            w_state[i]   = (r_sync2[i] != r_db[i]) ? ST_COUNTING : ST_STABLE;
            w_cnt_nxt[i] = r_cnt[i];
            case (w_state[i])
                ST_STABLE: begin
                    w_cnt_nxt[i] = '0;
                end
                ST_COUNTING: begin
                    if (r_cnt[i] == LP_CNT_LAST) begin
                        w_db_nxt[i]   = r_sync2[i];
                        w_rise_nxt[i] = r_sync2[i];
                        w_fall_nxt[i] = ~r_sync2[i];
                        w_cnt_nxt[i]  = '0;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                    end
                end
                default: begin
                    w_cnt_nxt[i] = '0;
                end
            endcase
            w_busy_nxt = w_busy_nxt | (w_cnt_nxt[i] != '0);
        end
    end

    assign sw_db   = r_db;
    assign sw_rise = r_rise;
    assign sw_fall = r_fall;
    assign busy    = r_busy;

endmodule
